// File: rtl/lcd_text_refresh.sv
// lcd_text_refresh
// ----------------
// Write-only controller for a 16x2 HD44780-style character LCD on an 8-bit bus.
// After reset it idles for the panel's power-up time and then sends the init
// commands (function set, display on, entry mode, clear). After the clear
// settle time it refreshes both lines forever:
//   SNAP -> addr 0x80 -> 16 chars -> addr 0xC0 -> 16 chars -> SNAP ...
// Each bus transaction has four phases of STEP_CYCLES clocks each:
// setup, enable high, hold, wait. RS and DATA stay stable for all four phases.
//
// The text inputs are latched into a snapshot only in SNAP, so one frame
// always shows text from a single moment.
//
// Optional build macro LCD_CHANGE_ONLY_EN: SNAP compares the incoming text
// with the last frame that was fully written. If they are equal, the block
// stays in SNAP with the bus idle. The first frame after init is always
// written.
//
// Ports:
//   clk                   system clock
//   reset                 synchronous, active-high reset
//   textdata_a..h [31:0]  four ASCII chars each, [31:24] leftmost;
//                         a..d form line 1, e..h form line 2
//   lcd_rs                0 = command, 1 = character data
//   lcd_rw                tied to 0 (write only)
//   lcd_en                enable strobe
//   lcd_data [7:0]        LCD data bus
//   init_done             high from the end of init until reset
//   frame_done            one-cycle pulse in the last cycle of line 2's final char
module lcd_text_refresh #(
  parameter int STEP_CYCLES  = 2000,
  parameter int POWERUP_WAIT = 40000,
  parameter int CLEAR_WAIT   = 4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] textdata_a,
  input  logic [31:0] textdata_b,
  input  logic [31:0] textdata_c,
  input  logic [31:0] textdata_d,
  input  logic [31:0] textdata_e,
  input  logic [31:0] textdata_f,
  input  logic [31:0] textdata_g,
  input  logic [31:0] textdata_h,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic [7:0]  lcd_data,
  output logic        init_done,
  output logic        frame_done
);

  localparam int MAX_WAIT =
    (STEP_CYCLES > POWERUP_WAIT)
      ? ((STEP_CYCLES  > CLEAR_WAIT) ? STEP_CYCLES  : CLEAR_WAIT)
      : ((POWERUP_WAIT > CLEAR_WAIT) ? POWERUP_WAIT : CLEAR_WAIT);
  localparam int CW = $clog2(MAX_WAIT + 1);

  localparam logic [CW-1:0] STEP_LAST  = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] PWRUP_LAST = CW'(POWERUP_WAIT - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_WAIT - 1);

  typedef enum logic [2:0] {
    PWRUP, INIT, CLRWAIT, SNAP, ADDR1, LINE1, ADDR2, LINE2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;      // cycles within a phase or a wait
  logic [1:0]    phase_q, phase_d;  // bus phase 0..3; wraps to 0 after each transaction
  logic [4:0]    idx_q, idx_d;      // init command index, or char index 0..31
  logic          init_done_q, init_done_d;
  logic [255:0]  snap_q;
  logic          snap_load;
  logic          in_xact;
  logic          step_end;
  logic          xact_end;
  logic [7:0]    init_cmd;
  logic [7:0]    cur_char;
  logic [255:0]  text_cat;

  assign text_cat = {textdata_a, textdata_b, textdata_c, textdata_d,
                     textdata_e, textdata_f, textdata_g, textdata_h};

  // Char 0 is the most significant byte of the snapshot.
  assign cur_char = snap_q[8 * (31 - int'(idx_q)) +: 8];

  assign step_end = (cnt_q == STEP_LAST);
  assign xact_end = step_end && (phase_q == 2'd3);

  always_comb begin
    case (idx_q[1:0])
      2'd0:    init_cmd = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
      2'd1:    init_cmd = 8'h0C;  // display on, cursor off
      2'd2:    init_cmd = 8'h06;  // auto-increment, no shift
      default: init_cmd = 8'h01;  // clear display
    endcase
  end

`ifdef LCD_CHANGE_ONLY_EN
  logic [255:0] last_q;
  logic         last_valid_q;
`endif

  // NOTE: every signal assigned in this block gets a default first, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    snap_load   = 1'b0;
    in_xact     = 1'b0;
    lcd_rs      = 1'b0;
    lcd_en      = 1'b0;
    lcd_data    = 8'h00;
    frame_done  = 1'b0;

    case (state_q)
      PWRUP: begin
        if (cnt_q == PWRUP_LAST) begin
          state_d = INIT;
          cnt_d   = '0;
          phase_d = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      INIT: begin
        in_xact  = 1'b1;
        lcd_data = init_cmd;
        if (xact_end) begin
          if (idx_q == 5'd3) state_d = CLRWAIT;
          else               idx_d   = idx_q + 1'b1;
        end
      end
      CLRWAIT: begin
        if (cnt_q == CLEAR_LAST) begin
          state_d     = SNAP;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SNAP: begin
        snap_load = 1'b1;
`ifdef LCD_CHANGE_ONLY_EN
        if (!last_valid_q || (text_cat != last_q)) state_d = ADDR1;
`else
        state_d = ADDR1;
`endif
      end
      ADDR1: begin
        in_xact  = 1'b1;
        lcd_data = 8'h80;
        if (xact_end) begin
          state_d = LINE1;
          idx_d   = 5'd0;
        end
      end
      LINE1: begin
        in_xact  = 1'b1;
        lcd_rs   = 1'b1;
        lcd_data = cur_char;
        if (xact_end) begin
          if (idx_q == 5'd15) state_d = ADDR2;
          else                idx_d   = idx_q + 1'b1;
        end
      end
      ADDR2: begin
        in_xact  = 1'b1;
        lcd_data = 8'hC0;
        if (xact_end) begin
          state_d = LINE2;
          idx_d   = 5'd16;
        end
      end
      LINE2: begin
        in_xact  = 1'b1;
        lcd_rs   = 1'b1;
        lcd_data = cur_char;
        if (xact_end) begin
          if (idx_q == 5'd31) begin
            state_d    = SNAP;
            frame_done = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = PWRUP;
    endcase

    // Shared phase timing for all command and character transactions.
    if (in_xact) begin
      lcd_en = (phase_q == 2'd1);
      if (step_end) begin
        cnt_d   = '0;
        phase_d = phase_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign lcd_rw    = 1'b0;
  assign init_done = init_done_q;

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PWRUP;
      cnt_q       <= '0;
      phase_q     <= '0;
      idx_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
    end
  end

  // NOTE: the snapshot is pure datapath storage and has no reset. It is
  // always loaded in SNAP before any character is read from it.
  always_ff @(posedge clk) begin
    if (snap_load) snap_q <= text_cat;
  end

`ifdef LCD_CHANGE_ONLY_EN
  always_ff @(posedge clk) begin
    if (reset)           last_valid_q <= 1'b0;
    else if (frame_done) last_valid_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (frame_done) last_q <= snap_q;
  end
`endif

endmodule

// File: tb/tb_lcd_text_refresh.sv
// Self-checking bench for lcd_text_refresh with short timing parameters
// (STEP=4, POWERUP=16, CLEAR=8).
// A timeline model walks the bus sequence: power-up idle, init commands,
// clear wait, then SNAP plus frame, repeated. The model restarts whenever a
// clock edge samples reset high. A negedge compare process checks every
// output against the model. Literal checks on captured transactions and
// cycle numbers pin the model to hand-computed values.
`timescale 1ns/1ps
module tb_lcd_text_refresh;

  localparam int STEP = 4;
  localparam int PW   = 16;
  localparam int CW   = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] txt [8];
  logic        lcd_rs, lcd_rw, lcd_en, init_done, frame_done;
  logic [7:0]  lcd_data;

  always #5 clk = ~clk;

  lcd_text_refresh #(
    .STEP_CYCLES (STEP),
    .POWERUP_WAIT(PW),
    .CLEAR_WAIT  (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .textdata_a(txt[0]),
    .textdata_b(txt[1]),
    .textdata_c(txt[2]),
    .textdata_d(txt[3]),
    .textdata_e(txt[4]),
    .textdata_f(txt[5]),
    .textdata_g(txt[6]),
    .textdata_h(txt[7]),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en),
    .lcd_data  (lcd_data),
    .init_done (init_done),
    .frame_done(frame_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Cycle index since the last reset edge. 0 is the first power-up cycle.
  int since_rst = 0;
  always @(posedge clk) since_rst <= reset ? 0 : since_rst + 1;

  // ---------------- behavioural model ----------------
  logic       exp_bus = 1'b0, exp_rs = 1'b0, exp_en = 1'b0, exp_fd = 1'b0, exp_init = 1'b0;
  logic [7:0] exp_data = 8'h00;
  bit         chk_on = 1'b0;
  bit         abort  = 1'b0;
  logic [31:0] snap_m [8];
`ifdef LCD_CHANGE_ONLY_EN
  logic [31:0] last_m [8];
  bit          last_valid_m;
`endif

  function automatic logic [7:0] char_at(input int i);
    logic [31:0] w;
    w = snap_m[i / 4];
    return w[31 - 8 * (i % 4) -: 8];
  endfunction

  // Set expectations for one cycle, then wait for the edge that ends it.
  task automatic cyc_out(input logic bus, input logic rs, input logic [7:0] d,
                         input logic en, input logic fd);
    exp_bus = bus; exp_rs = rs; exp_data = d; exp_en = en; exp_fd = fd;
    @(posedge clk);
    if (reset) abort = 1'b1;
  endtask

  task automatic xact(input logic rs, input logic [7:0] d, input logic last);
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < STEP; c++) begin
        cyc_out(1'b1, rs, d, p == 1, last && (p == 3) && (c == STEP - 1));
        if (abort) return;
      end
    end
  endtask

  task automatic run_model();
    logic [7:0] cmds [4];
    bit         same;
    cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h06; cmds[3] = 8'h01;
    abort = 1'b0;
    exp_init = 1'b0;
`ifdef LCD_CHANGE_ONLY_EN
    last_valid_m = 1'b0;
`endif
    cyc_out(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);   // first cycle out of reset: reset values
    if (abort) return;
    for (int i = 1; i < PW; i++) begin
      cyc_out(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      if (abort) return;
    end
    for (int k = 0; k < 4; k++) begin
      xact(1'b0, cmds[k], 1'b0);
      if (abort) return;
    end
    for (int i = 0; i < CW; i++) begin
      cyc_out(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      if (abort) return;
    end
    exp_init = 1'b1;
    forever begin
      cyc_out(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);  // SNAP
      if (abort) return;
      snap_m = txt;
      same = 1'b0;
`ifdef LCD_CHANGE_ONLY_EN
      same = last_valid_m;
      for (int w = 0; w < 8; w++) if (snap_m[w] != last_m[w]) same = 1'b0;
`endif
      if (!same) begin
        xact(1'b0, 8'h80, 1'b0);
        if (abort) return;
        for (int i = 0; i < 16; i++) begin
          xact(1'b1, char_at(i), 1'b0);
          if (abort) return;
        end
        xact(1'b0, 8'hC0, 1'b0);
        if (abort) return;
        for (int i = 16; i < 32; i++) begin
          xact(1'b1, char_at(i), i == 31);
          if (abort) return;
        end
`ifdef LCD_CHANGE_ONLY_EN
        last_m = snap_m;
        last_valid_m = 1'b1;
`endif
      end
    end
  endtask

  initial begin
    do @(posedge clk); while (!reset);
    chk_on = 1'b1;
    forever run_model();
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      check("en", lcd_en, exp_en);
      check("rw", lcd_rw, 1'b0);
      check("init_done", init_done, exp_init);
      check("frame_done", frame_done, exp_fd);
      if (exp_bus) begin
        check("rs", lcd_rs, exp_rs);
        check("data", lcd_data, exp_data);
      end
    end
  end

  // ---------------- transaction monitor ----------------
  logic [8:0] txn_q[$];
  int         en_cyc_q[$];
  int         fd_q[$];
  int         init_cyc = -1;
  int         en_run = 0;
  logic       prev_en = 1'b0, prev_init = 1'b0;

  always @(negedge clk) begin
    if (lcd_en && !prev_en) begin
      txn_q.push_back({lcd_rs, lcd_data});
      en_cyc_q.push_back(since_rst);
    end
    // A strobe cut short by reset ends in cycle 0 and is not a timing error.
    if (!lcd_en && prev_en && since_rst != 0) check("en_width", en_run, STEP);
    en_run = lcd_en ? en_run + 1 : 0;
    prev_en = lcd_en;
    if (frame_done) fd_q.push_back(since_rst);
    if (init_done && !prev_init) init_cyc = since_rst;
    prev_init = init_done;
  end

  task automatic wait_fd(input int n, input int budget);
    for (int i = 0; i < budget && fd_q.size() < n; i++) @(negedge clk);
    check("frame_done_timeout", fd_q.size() >= n, 1'b1);
  endtask

  function automatic logic [8:0] txn_at(input int i);
    return (i < txn_q.size()) ? txn_q[i] : 9'h1FF;
  endfunction

  function automatic int fd_at(input int i);
    return (i < fd_q.size()) ? fd_q[i] : -1;
  endfunction

  // Init command strobes, init_done and the first frame, relative to reset release.
  task automatic check_init_and_first_frame();
    check("en_cyc0", (en_cyc_q.size() > 3) ? en_cyc_q[0] : -1, 20);
    check("en_cyc3", (en_cyc_q.size() > 3) ? en_cyc_q[3] : -1, 68);
    check("cmd38", txn_at(0), 9'h038);
    check("cmd0C", txn_at(1), 9'h00C);
    check("cmd06", txn_at(2), 9'h006);
    check("cmd01", txn_at(3), 9'h001);
    check("init_cyc", init_cyc, 88);
    check("fd0_cyc", fd_at(0), 632);
    check("addr1", txn_at(4), 9'h080);
    check("chr0", txn_at(5), 9'h131);
    check("chr1", txn_at(6), 9'h132);
    check("chr2", txn_at(7), 9'h13A);
    check("chr3", txn_at(8), 9'h134);
    check("chr4", txn_at(9), 9'h120);
    check("addr2", txn_at(21), 9'h0C0);
    check("chr31", txn_at(37), 9'h120);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    txt[0] = 32'h31323A34;
    for (int i = 1; i < 8; i++) txt[i] = 32'h20202020;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_en", lcd_en, 1'b0);
    check("rst_data", lcd_data, 8'h00);
    check("rst_init", init_done, 1'b0);
    reset = 1'b0;

    wait_fd(1, 800);
    check_init_and_first_frame();

`ifdef LCD_CHANGE_ONLY_EN
    // Constant text: no further frames and no bus activity.
    repeat (700) @(negedge clk);
    check("idle_fd", fd_q.size(), 1);
    check("idle_txn", txn_q.size(), 38);
    txt[7] = 32'h20202041;
    wait_fd(2, 800);
    check("new_last_chr", txn_at(71), 9'h141);
    repeat (700) @(negedge clk);
    check("idle2_fd", fd_q.size(), 2);
    check("idle2_txn", txn_q.size(), 72);
`else
    // Change text during frame 2's LINE2; frame 3 must show it, frame 2 must not.
    for (int i = 0; i < 2000 && since_rst != 930; i++) @(negedge clk);
    txt[0] = 32'h35363A37;
    txt[7] = 32'h20202041;
    wait_fd(3, 1500);
    check("f2_chr0", txn_at(39), 9'h131);
    check("f2_chr31", txn_at(71), 9'h120);
    check("f3_chr0", txn_at(73), 9'h135);
    check("f3_chr3", txn_at(76), 9'h137);
    check("f3_chr31", txn_at(105), 9'h141);
    check("fd1_cyc", fd_at(1), 1177);
    check("fd2_cyc", fd_at(2), 1722);

    // Reset during the enable phase of a character write.
    for (int i = 0; i < 200 && !(lcd_en && lcd_rs); i++) @(negedge clk);
    check("char_strobe_seen", lcd_en && lcd_rs, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_en", lcd_en, 1'b0);
    check("mid_rst_data", lcd_data, 8'h00);
    check("mid_rst_init", init_done, 1'b0);
    reset = 1'b0;
    txn_q.delete();
    en_cyc_q.delete();
    fd_q.delete();
    init_cyc = -1;
    txt[0] = 32'h31323A34;
    txt[7] = 32'h20202020;
    wait_fd(1, 800);
    check_init_and_first_frame();
`endif

    repeat (20) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
